// File: rtl/dec_if.sv
// rtl/dec_if.sv - fetch/decode handshake bundle: IF/ID contents in, stall and early-JAL redirect out
interface dec_if;
  logic        i_vld;
  logic [31:0] i_pc;
  logic [31:0] i_nxt_pc;
  logic [31:0] i_imem_rdata;
  logic        i_flush;
  logic        o_hold;
  logic        o_jal_de;
  logic [31:0] o_immediate_de;

  modport master (
    output i_vld, i_pc, i_nxt_pc, i_imem_rdata, i_flush,
    input  o_hold, o_jal_de, o_immediate_de
  );

  modport slave (
    input  i_vld, i_pc, i_nxt_pc, i_imem_rdata, i_flush,
    output o_hold, o_jal_de, o_immediate_de
  );
endinterface

// File: rtl/dec.sv
// rtl/dec.sv - RV32I decode stage with load-use stall, flush, EBREAK halt and ID/EX register
module dec #(
  parameter logic [31:0] RESET_ADDR = 32'h00000000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  dec_if.slave        bus,
  output logic [4:0]  o_rs1_raddr,
  output logic [4:0]  o_rs2_raddr,
  output logic        o_vld,
  output logic [31:0] o_pc,
  output logic [31:0] o_nxt_pc,
  output logic [4:0]  o_rd,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [31:0] o_imm,
  output logic [2:0]  o_opsel,
  output logic        o_funct7b5,
  output logic        o_alusrc,
  output logic        o_regwr,
  output logic        o_memrd,
  output logic        o_memwr,
  output logic        o_branch,
  output logic        o_jal,
  output logic        o_jalr,
  output logic        o_lui,
  output logic        o_auipc,
  output logic        o_illegal,
  output logic        o_halt
);
  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_STALL = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] w_ins;
  logic [4:0]  w_op, w_rd, w_rs1, w_rs2;
  logic        w_lo_ok, w_lui, w_auipc, w_jal, w_jalr, w_br, w_ld, w_st, w_opi, w_opr;
  logic        w_ecall, w_ebreak, w_legal, w_rs1_used, w_rs2_used, w_regwr, w_hazard, w_hold;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm;

  assign w_ins    = bus.i_imem_rdata;
  assign w_op     = w_ins[6:2];
  assign w_lo_ok  = (w_ins[1:0] == 2'b11);
  assign w_rd     = w_ins[11:7];
  assign w_rs1    = w_ins[19:15];
  assign w_rs2    = w_ins[24:20];

  assign w_lui    = w_lo_ok && (w_op == 5'b01101);
  assign w_auipc  = w_lo_ok && (w_op == 5'b00101);
  assign w_jal    = w_lo_ok && (w_op == 5'b11011);
  assign w_jalr   = w_lo_ok && (w_op == 5'b11001);
  assign w_br     = w_lo_ok && (w_op == 5'b11000);
  assign w_ld     = w_lo_ok && (w_op == 5'b00000);
  assign w_st     = w_lo_ok && (w_op == 5'b01000);
  assign w_opi    = w_lo_ok && (w_op == 5'b00100);
  assign w_opr    = w_lo_ok && (w_op == 5'b01100);
  // Only the two environment calls are legal SYSTEM encodings; CSR forms are not supported.
  assign w_ecall  = (w_ins == 32'h00000073);
  assign w_ebreak = (w_ins == 32'h00100073);
  assign w_legal  = w_lui | w_auipc | w_jal | w_jalr | w_br | w_ld | w_st | w_opi | w_opr
                  | w_ecall | w_ebreak;

  assign w_imm_i = {{20{w_ins[31]}}, w_ins[31:20]};
  assign w_imm_s = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
  assign w_imm_b = {{19{w_ins[31]}}, w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
  assign w_imm_u = {w_ins[31:12], 12'b0};
  assign w_imm_j = {{11{w_ins[31]}}, w_ins[31], w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0};

  always_comb begin
    w_imm = 32'd0;
    if (w_jalr || w_ld || w_opi)  w_imm = w_imm_i;
    else if (w_st)                w_imm = w_imm_s;
    else if (w_br)                w_imm = w_imm_b;
    else if (w_lui || w_auipc)    w_imm = w_imm_u;
    else if (w_jal)               w_imm = w_imm_j;
  end

  assign w_rs1_used = w_jalr | w_br | w_ld | w_st | w_opi | w_opr;
  assign w_rs2_used = w_br | w_st | w_opr;
  assign w_regwr    = (w_lui | w_auipc | w_jal | w_jalr | w_ld | w_opi | w_opr) && (w_rd != 5'd0);

  // Hazard only against a load already sitting in ID/EX; the STALL cycle never re-checks.
  assign w_hazard = (r_state == S_RUN) && bus.i_vld && o_vld && o_memrd && (o_rd != 5'd0)
                 && ((w_rs1_used && (o_rd == w_rs1)) || (w_rs2_used && (o_rd == w_rs2)));
  assign w_hold   = !i_rst && ((r_state == S_HALT) || (w_hazard && !bus.i_flush));

  assign bus.o_hold         = w_hold;
  assign bus.o_jal_de       = bus.i_vld && w_jal && !w_hold && !bus.i_flush && (r_state == S_RUN);
  assign bus.o_immediate_de = w_imm_j;
  assign o_rs1_raddr        = w_rs1;
  assign o_rs2_raddr        = w_rs2;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_RUN;
      o_vld      <= 1'b0;
      o_pc       <= RESET_ADDR;
      o_nxt_pc   <= RESET_ADDR + 32'd4;
      o_rd       <= 5'd0;
      o_rs1      <= 5'd0;
      o_rs2      <= 5'd0;
      o_imm      <= 32'd0;
      o_opsel    <= 3'd0;
      o_funct7b5 <= 1'b0;
      o_alusrc   <= 1'b0;
      o_regwr    <= 1'b0;
      o_memrd    <= 1'b0;
      o_memwr    <= 1'b0;
      o_branch   <= 1'b0;
      o_jal      <= 1'b0;
      o_jalr     <= 1'b0;
      o_lui      <= 1'b0;
      o_auipc    <= 1'b0;
      o_illegal  <= 1'b0;
      o_halt     <= 1'b0;
    end else begin
      // Bubble by default; address/register fields keep their last value.
      o_vld      <= 1'b0;
      o_opsel    <= 3'd0;
      o_funct7b5 <= 1'b0;
      o_alusrc   <= 1'b0;
      o_regwr    <= 1'b0;
      o_memrd    <= 1'b0;
      o_memwr    <= 1'b0;
      o_branch   <= 1'b0;
      o_jal      <= 1'b0;
      o_jalr     <= 1'b0;
      o_lui      <= 1'b0;
      o_auipc    <= 1'b0;
      o_illegal  <= 1'b0;
      o_halt     <= 1'b0;
      if (r_state == S_HALT) begin
        o_halt <= 1'b1;
      end else if (bus.i_flush || !bus.i_vld) begin
        r_state <= S_RUN;
      end else if (w_hazard) begin
        r_state <= S_STALL;
      end else begin
        r_state    <= w_ebreak ? S_HALT : S_RUN;
        o_vld      <= 1'b1;
        o_pc       <= bus.i_pc;
        o_nxt_pc   <= bus.i_nxt_pc;
        o_rd       <= w_rd;
        o_rs1      <= w_rs1;
        o_rs2      <= w_rs2;
        o_imm      <= w_imm;
        o_opsel    <= w_legal ? w_ins[14:12] : 3'd0;
        o_funct7b5 <= (w_opi || w_opr) && w_ins[30];
        o_alusrc   <= w_opi | w_ld | w_st | w_jalr | w_lui | w_auipc;
        o_regwr    <= w_regwr;
        o_memrd    <= w_ld;
        o_memwr    <= w_st;
        o_branch   <= w_br;
        o_jal      <= w_jal;
        o_jalr     <= w_jalr;
        o_lui      <= w_lui;
        o_auipc    <= w_auipc;
        o_illegal  <= !w_legal;
        o_halt     <= w_ebreak;
      end
    end
  end
endmodule

// File: tb/tb_dec.sv
// tb/tb_dec.sv - directed-vector bench for dec with immediate-assertion checks
module tb_dec;
  logic        i_clk;
  logic        i_rst;
  logic [4:0]  o_rs1_raddr, o_rs2_raddr, o_rd, o_rs1, o_rs2;
  logic        o_vld, o_funct7b5, o_alusrc, o_regwr, o_memrd, o_memwr, o_branch;
  logic        o_jal, o_jalr, o_lui, o_auipc, o_illegal, o_halt;
  logic [31:0] o_pc, o_nxt_pc, o_imm;
  logic [2:0]  o_opsel;
  int          n_vec = 0;
  int          n_err = 0;

  dec_if u_if ();

  dec #(.RESET_ADDR(32'h00000100)) u_dut (
    .i_clk(i_clk), .i_rst(i_rst), .bus(u_if),
    .o_rs1_raddr(o_rs1_raddr), .o_rs2_raddr(o_rs2_raddr),
    .o_vld(o_vld), .o_pc(o_pc), .o_nxt_pc(o_nxt_pc), .o_rd(o_rd), .o_rs1(o_rs1), .o_rs2(o_rs2),
    .o_imm(o_imm), .o_opsel(o_opsel), .o_funct7b5(o_funct7b5), .o_alusrc(o_alusrc),
    .o_regwr(o_regwr), .o_memrd(o_memrd), .o_memwr(o_memwr), .o_branch(o_branch),
    .o_jal(o_jal), .o_jalr(o_jalr), .o_lui(o_lui), .o_auipc(o_auipc),
    .o_illegal(o_illegal), .o_halt(o_halt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [31:0] ins, input logic [31:0] pc, input logic fl);
    u_if.i_vld        = vld;
    u_if.i_imem_rdata = ins;
    u_if.i_pc         = pc;
    u_if.i_nxt_pc     = pc + 32'd4;
    u_if.i_flush      = fl;
    #1;
  endtask

  initial begin
    i_rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    chk("hold_in_reset", {31'd0, u_if.o_hold}, 32'd0);
    tick();
    chk("rst_vld", {31'd0, o_vld}, 32'd0);
    chk("rst_pc", o_pc, 32'h00000100);
    chk("rst_nxt_pc", o_nxt_pc, 32'h00000104);
    chk("rst_ctl", {o_halt, o_regwr, o_memrd, o_memwr, o_illegal}, 32'd0);
    chk("rst_imm", o_imm, 32'd0);
    i_rst = 1'b0;

    // ADDI x1,x0,-5
    drive(1'b1, 32'hFFB00093, 32'h200, 1'b0);
    chk("addi_rs1_raddr", {27'd0, o_rs1_raddr}, 32'd0);
    chk("addi_rs2_raddr", {27'd0, o_rs2_raddr}, 32'd27);
    tick();
    chk("addi_vld", {31'd0, o_vld}, 32'd1);
    chk("addi_rd", {27'd0, o_rd}, 32'd1);
    chk("addi_imm", o_imm, 32'hFFFFFFFB);
    chk("addi_regwr_alusrc", {30'd0, o_regwr, o_alusrc}, 32'd3);
    chk("addi_pc", o_pc, 32'h200);
    chk("addi_nxt_pc", o_nxt_pc, 32'h204);

    // LW x5,0(x2) then ADD x6,x5,x7: one stall cycle
    drive(1'b1, 32'h00012283, 32'h204, 1'b0);
    tick();
    chk("lw_memrd_rd", {26'd0, o_memrd, o_rd}, {26'd0, 1'b1, 5'd5});
    drive(1'b1, 32'h00728333, 32'h208, 1'b0);
    chk("lu_hold", {31'd0, u_if.o_hold}, 32'd1);
    tick();
    chk("lu_bubble", {30'd0, o_vld, o_memrd}, 32'd0);
    chk("lu_hold_released", {31'd0, u_if.o_hold}, 32'd0);
    tick();
    chk("lu_add_vld", {31'd0, o_vld}, 32'd1);
    chk("lu_add_rs1", {27'd0, o_rs1}, 32'd5);
    chk("lu_add_rs2_rd", {22'd0, o_rs2, o_rd}, {22'd0, 5'd7, 5'd6});
    chk("lu_add_pc", o_pc, 32'h208);
    chk("lu_add_imm_alusrc", {o_imm[30:0], o_alusrc}, 32'd0);

    // LW x0 then ADD using x0: no stall
    drive(1'b1, 32'h00012003, 32'h20C, 1'b0);
    tick();
    chk("lwx0_regwr", {31'd0, o_regwr}, 32'd0);
    drive(1'b1, 32'h00700333, 32'h210, 1'b0);
    chk("x0_no_hold", {31'd0, u_if.o_hold}, 32'd0);
    tick();
    chk("x0_add_vld", {31'd0, o_vld}, 32'd1);

    // Hazard cancelled by flush, then JAL proves state is RUN
    drive(1'b1, 32'h00012283, 32'h214, 1'b0);
    tick();
    drive(1'b1, 32'h00728333, 32'h218, 1'b1);
    chk("flush_hold", {31'd0, u_if.o_hold}, 32'd0);
    tick();
    chk("flush_bubble", {31'd0, o_vld}, 32'd0);
    drive(1'b1, 32'h008000EF, 32'h300, 1'b0);
    chk("jal_de", {31'd0, u_if.o_jal_de}, 32'd1);
    chk("jal_imm_de", u_if.o_immediate_de, 32'd8);
    tick();
    chk("jal_ctl", {29'd0, o_jal, o_regwr, o_vld}, 32'd7);
    chk("jal_imm", o_imm, 32'd8);

    // BEQ x1,x2,-4 and LUI x3,0x12345
    drive(1'b1, 32'hFE208EE3, 32'h304, 1'b0);
    chk("beq_jal_de", {31'd0, u_if.o_jal_de}, 32'd0);
    tick();
    chk("beq_imm", o_imm, 32'hFFFFFFFC);
    chk("beq_ctl", {30'd0, o_branch, o_regwr}, 32'd2);
    drive(1'b1, 32'h123451B7, 32'h308, 1'b0);
    tick();
    chk("lui_imm", o_imm, 32'h12345000);
    chk("lui_ctl", {30'd0, o_lui, o_regwr}, 32'd3);

    // Illegal opcode 0
    drive(1'b1, 32'h00000000, 32'h30C, 1'b0);
    tick();
    chk("ill_ctl", {28'd0, o_illegal, o_regwr, o_memwr, o_vld}, 32'h9);

    drive(1'b0, 32'h00000000, 32'h310, 1'b0);
    tick();
    chk("novld_bubble", {31'd0, o_vld}, 32'd0);

    // EBREAK halts; flush ignored; reset clears
    drive(1'b1, 32'h00100073, 32'h314, 1'b0);
    tick();
    chk("ebreak_halt_vld", {30'd0, o_halt, o_vld}, 32'd3);
    chk("halt_hold", {31'd0, u_if.o_hold}, 32'd1);
    drive(1'b1, 32'hFFB00093, 32'h318, 1'b1);
    tick();
    chk("halt_bubble", {30'd0, o_halt, o_vld}, 32'd2);
    tick();
    chk("halt_hold_sticky", {31'd0, u_if.o_hold}, 32'd1);
    i_rst = 1'b1;
    #1;
    chk("halt_rst_hold", {31'd0, u_if.o_hold}, 32'd0);
    tick();
    chk("halt_rst_clear", {30'd0, o_halt, o_vld}, 32'd0);
    chk("halt_rst_pc", o_pc, 32'h00000100);
    i_rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    chk("post_rst_hold", {31'd0, u_if.o_hold}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dec.md
DEC -- requirements
Module: dec

Interface
REQ-001 Parameter RESET_ADDR, default 32'h00000000, PC value driven on o_pc while the ID/EX register holds no valid instruction after reset.
REQ-002 i_clk  input  1  global clock; all state updates on rising edge.
REQ-003 i_rst  input  1  reset, synchronous, active-high.
REQ-004 i_vld, i_pc[31:0], i_nxt_pc[31:0]  input  1/32/32  IF/ID register contents (valid, instruction address, sequential next PC).
REQ-005 i_imem_rdata  input  32  instruction word for i_pc.
REQ-006 i_flush  input  1  taken branch/jalr resolved in EX; kill the instruction in decode.
REQ-007 o_hold  output  1  load-use stall request to fetch (freezes PC and IF/ID register).
REQ-008 o_rs1_raddr, o_rs2_raddr  output  5 each  combinational register-file read addresses from i_imem_rdata[19:15], [24:20].
REQ-009 o_jal_de, o_immediate_de  output  1/32  combinational early-JAL redirect and J-immediate to fetch; o_jal_de gated by i_vld, !o_hold, !i_flush, state RUN.
REQ-010 ID/EX outputs (registered): o_vld 1, o_pc 32, o_nxt_pc 32, o_rd 5, o_rs1 5, o_rs2 5, o_imm 32, o_opsel 3 (funct3), o_funct7b5 1, o_alusrc 1, o_regwr 1, o_memrd 1, o_memwr 1, o_branch 1, o_jal 1, o_jalr 1, o_lui 1, o_auipc 1, o_illegal 1, o_halt 1.

Function
REQ-011 Decode RV32I opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, SYSTEM (EBREAK/ECALL); any other opcode, or bits[1:0]!=2'b11, sets o_illegal with o_regwr=0, o_memrd=0, o_memwr=0.
REQ-012 Immediates sign-extended from bit 31: I, S, B (bit0=0), U (low 12 bits zero), J (bit0=0); R-type o_imm=0.
REQ-013 o_regwr=0 whenever decoded rd is x0.
REQ-014 rs1 "used" for JALR, BRANCH, LOAD, STORE, OP-IMM, OP; rs2 "used" for BRANCH, STORE, OP only.
REQ-015 State machine RUN, STALL, HALT; reset state RUN.
REQ-016 Load-use hazard: in RUN, i_vld=1, ID/EX holds o_vld=1 and o_memrd=1 and o_rd!=0, and o_rd matches a used rs1/rs2 -> o_hold=1 combinationally, next state STALL, ID/EX loads a bubble (o_vld=0, all control outputs 0).
REQ-017 STALL lasts exactly one cycle: o_hold=0, decoded instruction enters ID/EX, next state RUN; no re-stall on the same instruction.
REQ-018 i_flush=1 -> ID/EX loads bubble next edge, o_hold forced 0, o_jal_de forced 0; flush overrides hazard and STALL (STALL -> RUN).
REQ-019 i_vld=0 -> bubble into ID/EX, no hazard check, o_hold=0.
REQ-020 EBREAK decoded in RUN/STALL, not flushed -> enters ID/EX with o_halt=1; next state HALT.
REQ-021 HALT: sticky until reset; ID/EX holds o_vld=0 bubbles except o_halt held 1; o_hold=1 constantly to freeze fetch; i_flush ignored.
REQ-022 Latency: instruction visible on ID/EX outputs one cycle after presentation (two when stalled).
REQ-023 o_pc, o_nxt_pc in ID/EX copied unmodified from i_pc, i_nxt_pc; no arithmetic on addresses.

Reset
REQ-024 i_rst=1 at edge: state RUN, o_vld=0, all control outputs 0, o_halt=0, o_imm=0, o_rd/o_rs1/o_rs2=0, o_pc=RESET_ADDR, o_nxt_pc=RESET_ADDR+4.
REQ-025 Reset overrides flush, stall and HALT in the same cycle; o_hold=0 while i_rst=1.

Verification
REQ-026 ADDI x1,x0,-5 (32'hFFB00093), i_vld=1 -> next cycle o_vld=1, o_rd=1, o_imm=32'hFFFFFFFB, o_regwr=1, o_alusrc=1.
REQ-027 LW x5,0(x2) then ADD x6,x5,x7 -> o_hold=1 one cycle, one bubble (o_vld=0), ADD emitted following cycle with o_rs1=5.
REQ-028 LW x0,0(x2) then ADD x6,x0,x7 -> no stall, o_hold stays 0.
REQ-029 Load-use hazard with i_flush=1 same cycle -> o_hold=0, bubble, state RUN.
REQ-030 EBREAK (32'h00100073) -> o_halt=1 next cycle, o_hold=1 every cycle after; i_rst clears both.
REQ-031 Opcode 7'b0000000 -> o_illegal=1, o_regwr=0, o_memwr=0, o_vld=1.
